// File: rtl/loteria_entrada_aposta_pkg.sv
// Shared definitions for the Loteria bet-entry stage.
// Holds the default bet geometry, counter widths and the FSM state encoding
// used by loteria_entrada_aposta and its interface.
package loteria_entrada_aposta_pkg;

  localparam int NUM_W_DEF       = 4;
  localparam int NUM_PICKS_DEF   = 5;
  localparam int NUM_MAX_DEF     = 15;
  localparam int MAX_APOSTAS_DEF = 4;

  // qtd, apostas and the stream index all share this width
  localparam int CNT_W     = 4;
  localparam int BUF_DEPTH = 2**CNT_W;

  typedef enum logic [2:0] {
    COLETA   = 3'd0,
    CHEIO    = 3'd1,
    ENVIA    = 3'd2,
    FIM      = 3'd3,
    FIM_JOGO = 3'd4
  } estado_t;

endpackage

// File: rtl/loteria_entrada_aposta_if.sv
// Keypad-side strobes and Loteria-side stream for the bet-entry stage.
//   tecla_ok/tecla   keyed number strobe
//   confirma         send the completed bet
//   cancela          discard the bet being entered
//   encerra          operator ends the game
//   numero/insere    number stream towards Loteria
//   fim              pulse after the last number of a bet
//   fim_jogo         game over level
//   erro             key rejected pulse
//   qtd/apostas      numbers in current bet / bets sent this game
// master: keypad/operator side, slave: the entry stage.
interface loteria_entrada_aposta_if
  import loteria_entrada_aposta_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF
);
  logic             tecla_ok;
  logic [NUM_W-1:0] tecla;
  logic             confirma;
  logic             cancela;
  logic             encerra;
  logic [NUM_W-1:0] numero;
  logic             insere;
  logic             fim;
  logic             fim_jogo;
  logic             erro;
  logic [CNT_W-1:0] qtd;
  logic [CNT_W-1:0] apostas;

  modport master (
    output tecla_ok, tecla, confirma, cancela, encerra,
    input  numero, insere, fim, fim_jogo, erro, qtd, apostas
  );

  modport slave (
    input  tecla_ok, tecla, confirma, cancela, encerra,
    output numero, insere, fim, fim_jogo, erro, qtd, apostas
  );
endinterface

// File: rtl/loteria_entrada_aposta_filtro_dup.sv
// Seen-mask for the numbers of the bet being entered.
//   clock, reset  clock and async active-high reset
//   tecla         number under test
//   marca         set seen[tecla] on the next edge
//   limpa         clear the whole mask on the next edge (wins over marca)
//   dup           tecla already in the current bet (combinational)
//   fora          tecla above NUM_MAX (combinational)
module loteria_entrada_aposta_filtro_dup #(
  parameter int NUM_W   = 4,
  parameter int NUM_MAX = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NUM_W-1:0] tecla,
  input  logic             marca,
  input  logic             limpa,
  output logic             dup,
  output logic             fora
);

  logic [2**NUM_W-1:0] seen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen <= '0;
    end else if (limpa) begin
      seen <= '0;
    end else if (marca) begin
      seen[tecla] <= 1'b1;
    end
  end

  assign dup  = seen[tecla];
  assign fora = (tecla > NUM_W'(NUM_MAX));

endmodule

// File: rtl/loteria_entrada_aposta.sv
// Bet-entry stage for the Loteria checker: collects NUM_PICKS distinct
// numbers from the keypad, streams them on confirmation and counts bets.
//   clock, reset  clock and async active-high reset
//   bus           loteria_entrada_aposta_if slave (keypad in, stream out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// COLETA   | entering a bet, accepting keys
// CHEIO    | bet complete, waiting for confirma
// ENVIA    | streaming buf_aposta[idx] with insere=1
// FIM      | fim pulse, bet counted, mask and qtd cleared on exit
// FIM_JOGO | game over, absorbing until reset
module loteria_entrada_aposta
  import loteria_entrada_aposta_pkg::*;
#(
  parameter int NUM_W       = NUM_W_DEF,
  parameter int NUM_PICKS   = NUM_PICKS_DEF,
  parameter int NUM_MAX     = NUM_MAX_DEF,
  parameter int MAX_APOSTAS = MAX_APOSTAS_DEF
) (
  input logic                    clock,
  input logic                    reset,
  loteria_entrada_aposta_if.slave bus
);

  estado_t          estado;
  logic [NUM_W-1:0] buf_aposta [BUF_DEPTH];
  logic [CNT_W-1:0] qtd_r;
  logic [CNT_W-1:0] apostas_r;
  logic [CNT_W-1:0] idx;
  logic [NUM_W-1:0] numero_r;
  logic             insere_r;
  logic             fim_r;
  logic             fim_jogo_r;
  logic             erro_r;

  logic dup;
  logic fora;
  logic em_entrada;
  logic aceita;
  logic limpa;

  assign em_entrada = (estado == COLETA) || (estado == CHEIO);

  // A key is taken only in COLETA and only when no higher-priority
  // strobe is present in the same cycle.
  assign aceita = (estado == COLETA) && bus.tecla_ok && !bus.encerra &&
                  !bus.cancela && !dup && !fora;

  assign limpa = (estado == FIM) ||
                 (em_entrada && (bus.encerra || bus.cancela));

  loteria_entrada_aposta_filtro_dup #(
    .NUM_W   (NUM_W),
    .NUM_MAX (NUM_MAX)
  ) u_filtro (
    .clock (clock),
    .reset (reset),
    .tecla (bus.tecla),
    .marca (aceita),
    .limpa (limpa),
    .dup   (dup),
    .fora  (fora)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= COLETA;
      qtd_r      <= '0;
      apostas_r  <= '0;
      idx        <= '0;
      numero_r   <= '0;
      insere_r   <= 1'b0;
      fim_r      <= 1'b0;
      fim_jogo_r <= 1'b0;
      erro_r     <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_aposta[i] <= '0;
      end
    end else begin
      erro_r <= 1'b0;
      fim_r  <= 1'b0;
      unique case (estado)
        COLETA: begin
          if (bus.encerra) begin
            qtd_r      <= '0;
            fim_jogo_r <= 1'b1;
            estado     <= FIM_JOGO;
          end else if (bus.cancela) begin
            qtd_r <= '0;
          end else if (bus.tecla_ok) begin
            if (dup || fora) begin
              erro_r <= 1'b1;
            end else begin
              buf_aposta[qtd_r] <= bus.tecla;
              qtd_r             <= qtd_r + 4'd1;
              if (qtd_r == CNT_W'(NUM_PICKS - 1)) begin
                estado <= CHEIO;
              end
            end
          end
        end

        CHEIO: begin
          if (bus.encerra) begin
            qtd_r      <= '0;
            fim_jogo_r <= 1'b1;
            estado     <= FIM_JOGO;
          end else if (bus.cancela) begin
            qtd_r  <= '0;
            estado <= COLETA;
          end else if (bus.confirma) begin
            // first number goes out on the same edge, so insere shows
            // up in the cycle right after confirma
            idx      <= '0;
            numero_r <= buf_aposta[0];
            insere_r <= 1'b1;
            estado   <= ENVIA;
          end else if (bus.tecla_ok) begin
            erro_r <= 1'b1;
          end
        end

        ENVIA: begin
          if (idx == CNT_W'(NUM_PICKS - 1)) begin
            insere_r <= 1'b0;
            fim_r    <= 1'b1;
            if (apostas_r != CNT_W'(MAX_APOSTAS)) begin
              apostas_r <= apostas_r + 4'd1;
            end
            estado <= FIM;
          end else begin
            idx      <= idx + 4'd1;
            numero_r <= buf_aposta[idx + 4'd1];
          end
        end

        FIM: begin
          qtd_r <= '0;
          if (apostas_r == CNT_W'(MAX_APOSTAS)) begin
            fim_jogo_r <= 1'b1;
            estado     <= FIM_JOGO;
          end else begin
            estado <= COLETA;
          end
        end

        FIM_JOGO: begin
          fim_jogo_r <= 1'b1;
        end

        default: begin
          estado <= COLETA;
        end
      endcase
    end
  end

  assign bus.numero   = numero_r;
  assign bus.insere   = insere_r;
  assign bus.fim      = fim_r;
  assign bus.fim_jogo = fim_jogo_r;
  assign bus.erro     = erro_r;
  assign bus.qtd      = qtd_r;
  assign bus.apostas  = apostas_r;

endmodule

// File: tb/tb_loteria_entrada_aposta.sv
// Directed bench for loteria_entrada_aposta: a default instance for the
// main flow and a NUM_MAX=7 instance for the range rejection.
module tb_loteria_entrada_aposta;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  loteria_entrada_aposta_if #(.NUM_W(4)) bus ();
  loteria_entrada_aposta_if #(.NUM_W(4)) bus7 ();

  loteria_entrada_aposta dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  loteria_entrada_aposta #(
    .NUM_W       (4),
    .NUM_PICKS   (5),
    .NUM_MAX     (7),
    .MAX_APOSTAS (4)
  ) dut7 (
    .clock (clock),
    .reset (reset),
    .bus   (bus7)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input int v);
    bus.tecla_ok = 1'b1;
    bus.tecla    = 4'(v);
    tick();
    bus.tecla_ok = 1'b0;
  endtask

  task automatic do_cancela();
    bus.cancela = 1'b1;
    tick();
    bus.cancela = 1'b0;
  endtask

  // confirm a full bet and follow it through the stream and the fim pulse
  task automatic stream_bet(input int a, input int b, input int c,
                            input int d, input int e, input int ap);
    int v[5];
    v = '{a, b, c, d, e};
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("insere[%0d]", i), bus.insere, 1);
      check_val($sformatf("numero[%0d]", i), bus.numero, v[i]);
      check_val($sformatf("fim_early[%0d]", i), bus.fim, 0);
      tick();
    end
    check_val("fim_pulse", bus.fim, 1);
    check_val("insere_at_fim", bus.insere, 0);
    check_val("apostas_at_fim", bus.apostas, ap);
    tick();
    check_val("fim_one_cycle", bus.fim, 0);
    check_val("qtd_after_fim", bus.qtd, 0);
  endtask

  task automatic full_bet(input int a, input int b, input int c,
                          input int d, input int e, input int ap);
    key(a); key(b); key(c); key(d); key(e);
    check_val("qtd_full", bus.qtd, 5);
    stream_bet(a, b, c, d, e, ap);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.tecla_ok  = 1'b0;
    bus.tecla     = '0;
    bus.confirma  = 1'b0;
    bus.cancela   = 1'b0;
    bus.encerra   = 1'b0;
    bus7.tecla_ok = 1'b0;
    bus7.tecla    = '0;
    bus7.confirma = 1'b0;
    bus7.cancela  = 1'b0;
    bus7.encerra  = 1'b0;
    reset = 1'b1;
    #11;
    check_val("rst_insere", bus.insere, 0);
    check_val("rst_fim", bus.fim, 0);
    check_val("rst_fim_jogo", bus.fim_jogo, 0);
    check_val("rst_erro", bus.erro, 0);
    check_val("rst_qtd", bus.qtd, 0);
    check_val("rst_apostas", bus.apostas, 0);
    check_val("rst_numero", bus.numero, 0);
    #1;
    reset = 1'b0;

    // T1: basic bet
    key(5); check_val("t1_erro_k1", bus.erro, 0);
    key(3); key(8); key(2);
    key(0); check_val("t1_erro_k5", bus.erro, 0);
    check_val("t1_qtd", bus.qtd, 5);
    stream_bet(5, 3, 8, 2, 0, 1);

    // T2: duplicate, then range on the NUM_MAX=7 instance
    key(5);
    key(5);
    check_val("t2_dup_erro", bus.erro, 1);
    check_val("t2_dup_qtd", bus.qtd, 1);
    tick();
    check_val("t2_erro_one_cycle", bus.erro, 0);
    do_cancela();
    check_val("t2_cancela_qtd", bus.qtd, 0);

    bus7.tecla_ok = 1'b1;
    bus7.tecla    = 4'd9;
    tick();
    bus7.tecla_ok = 1'b0;
    check_val("t2_range_erro", bus7.erro, 1);
    check_val("t2_range_qtd", bus7.qtd, 0);
    bus7.tecla_ok = 1'b1;
    bus7.tecla    = 4'd7;
    tick();
    bus7.tecla_ok = 1'b0;
    check_val("t2_edge_erro", bus7.erro, 0);
    check_val("t2_edge_qtd", bus7.qtd, 1);

    // T3: cancel clears the mask; key 1 is accepted again into slot 0
    key(1); key(2);
    do_cancela();
    key(1);
    check_val("t3_erro", bus.erro, 0);
    check_val("t3_qtd", bus.qtd, 1);
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    check_val("t3_confirma_incompleto", bus.insere, 0);
    key(4); key(6); key(7); key(9);
    check_val("t3_qtd_full", bus.qtd, 5);
    key(3);
    check_val("t3_cheio_erro", bus.erro, 1);
    check_val("t3_cheio_qtd", bus.qtd, 5);
    stream_bet(1, 4, 6, 7, 9, 2);
    check_val("t3_fim_jogo", bus.fim_jogo, 0);

    // T4: bets 3 and 4 end the game
    full_bet(0, 1, 2, 3, 4, 3);
    check_val("t4_fim_jogo_3", bus.fim_jogo, 0);
    full_bet(10, 11, 12, 13, 15, 4);
    check_val("t4_fim_jogo", bus.fim_jogo, 1);
    key(1);
    check_val("t4_no_erro", bus.erro, 0);
    check_val("t4_no_insere", bus.insere, 0);
    check_val("t4_qtd", bus.qtd, 0);
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    check_val("t4_confirma_insere", bus.insere, 0);
    check_val("t4_apostas_hold", bus.apostas, 4);

    // T5: reset in the middle of the stream
    reset = 1'b1;
    #2;
    reset = 1'b0;
    key(1); key(2); key(3); key(4); key(5);
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    tick();
    tick();
    check_val("t5_insere3", bus.insere, 1);
    check_val("t5_numero3", bus.numero, 3);
    #1;
    reset = 1'b1;
    #1;
    check_val("t5_insere_async", bus.insere, 0);
    check_val("t5_qtd", bus.qtd, 0);
    check_val("t5_apostas", bus.apostas, 0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val($sformatf("t5_no_fim[%0d]", i), bus.fim, 0);
    end
    check_val("t5_fim_jogo", bus.fim_jogo, 0);

    // T6: encerra beats tecla_ok with a partial bet
    key(1); key(2); key(3);
    check_val("t6_qtd3", bus.qtd, 3);
    bus.encerra  = 1'b1;
    bus.tecla_ok = 1'b1;
    bus.tecla    = 4'd4;
    tick();
    bus.encerra  = 1'b0;
    bus.tecla_ok = 1'b0;
    check_val("t6_fim_jogo", bus.fim_jogo, 1);
    check_val("t6_erro", bus.erro, 0);
    check_val("t6_qtd", bus.qtd, 0);
    check_val("t6_apostas", bus.apostas, 0);
    bus.confirma = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val($sformatf("t6_no_insere[%0d]", i), bus.insere, 0);
      check_val($sformatf("t6_no_fim[%0d]", i), bus.fim, 0);
    end
    bus.confirma = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
